// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand/writeback sequencer:
// FSM state encoding and the ALUctr operation codes.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUBU = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

endpackage

// File: rtl/alu_op_sequencer_reg_file.sv
// 2^REG_AW x N register file: two operand read ports, one debug read port,
// one synchronous write port, register 0 reads as zero, async clear.
module alu_op_sequencer_reg_file #(
  parameter int N      = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra_addr_i,
  output logic [N-1:0]      ra_data_o,
  input  logic [REG_AW-1:0] rb_addr_i,
  output logic [N-1:0]      rb_data_o,
  input  logic [REG_AW-1:0] rc_addr_i,
  output logic [N-1:0]      rc_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [N-1:0]      wd_i
);

  localparam int DEPTH = 1 << REG_AW;

  logic [N-1:0] regs_q [DEPTH];

  // NOTE: the whole array clears on reset, so it maps to flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign ra_data_o = (ra_addr_i == '0) ? '0 : regs_q[ra_addr_i];
  assign rb_data_o = (rb_addr_i == '0) ? '0 : regs_q[rb_addr_i];
  assign rc_data_o = (rc_addr_i == '0) ? '0 : regs_q[rc_addr_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Operand fetch / writeback sequencer around an external combinational ALU.
// Define OVF_WB_SUPPRESS_EN to drop the write-back of results that overflowed.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N      = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rs,
  input  logic [REG_AW-1:0] cmd_rt,
  input  logic [REG_AW-1:0] cmd_rd,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic [2:0]        alu_ctr,
  input  logic [N-1:0]      alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              done_valid,
  output logic [N-1:0]      done_result,
  output logic              done_zero,
  output logic              done_overflow,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [N-1:0]      dbg_data
);

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [REG_AW-1:0] rs_q, rt_q, rd_q;
  logic [N-1:0]      alu_a_q, alu_b_q, done_result_q;
  logic [2:0]        alu_ctr_q;
  logic              done_zero_q, done_ovf_q;

  logic              accept, load_ops, capture, wb_en;
  logic [N-1:0]      rs_data, rt_data;

  // NOTE: every output gets a default before the case, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    done_valid = 1'b0;
    accept     = 1'b0;
    load_ops   = 1'b0;
    capture    = 1'b0;
    wb_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        load_ops = 1'b1;
        state_d  = EXEC;
      end
      EXEC: begin
        capture = 1'b1;
        state_d = WB;
      end
      WB: begin
        done_valid = 1'b1;
`ifdef OVF_WB_SUPPRESS_EN
        wb_en      = !done_ovf_q;
`else
        wb_en      = 1'b1;
`endif
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rd_q          <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_ctr_q     <= '0;
      done_result_q <= '0;
      done_zero_q   <= 1'b0;
      done_ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= cmd_op;
        rs_q <= cmd_rs;
        rt_q <= cmd_rt;
        rd_q <= cmd_rd;
      end
      if (load_ops) begin
        alu_a_q   <= rs_data;
        alu_b_q   <= rt_data;
        alu_ctr_q <= op_q;
      end
      if (capture) begin
        done_result_q <= alu_result;
        done_zero_q   <= alu_zero;
        done_ovf_q    <= alu_overflow;
      end
    end
  end

  // Write-back lands at the WB exit edge, before any later READ samples the file.
  alu_op_sequencer_reg_file #(
    .N      (N),
    .REG_AW (REG_AW)
  ) u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_addr_i (rs_q),
    .ra_data_o (rs_data),
    .rb_addr_i (rt_q),
    .rb_data_o (rt_data),
    .rc_addr_i (dbg_addr),
    .rc_data_o (dbg_data),
    .we_i      (wb_en),
    .wa_i      (rd_q),
    .wd_i      (done_result_q)
  );

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_ctr       = alu_ctr_q;
  assign done_result   = done_result_q;
  assign done_zero     = done_zero_q;
  assign done_overflow = done_ovf_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural ALU stub.
// Expectations for r6 follow OVF_WB_SUPPRESS_EN when the bench is built with it.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int N      = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [REG_AW-1:0] cmd_rs, cmd_rt, cmd_rd;
  logic [N-1:0]      alu_a, alu_b;
  logic [2:0]        alu_ctr;
  logic [N-1:0]      alu_result;
  logic              alu_zero, alu_overflow;
  logic              done_valid;
  logic [N-1:0]      done_result;
  logic              done_zero, done_overflow;
  logic [REG_AW-1:0] dbg_addr;
  logic [N-1:0]      dbg_data;

  // Lets the bench load arbitrary constants through an ADDU r0,r0 command.
  logic              inj_en;
  logic [N-1:0]      inj_val;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.N(N), .REG_AW(REG_AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_rs        (cmd_rs),
    .cmd_rt        (cmd_rt),
    .cmd_rd        (cmd_rd),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_ctr       (alu_ctr),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .done_valid    (done_valid),
    .done_result   (done_result),
    .done_zero     (done_zero),
    .done_overflow (done_overflow),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  always_comb begin
    logic [N-1:0] r;
    logic         v;
    r = '0;
    v = 1'b0;
    unique case (alu_ctr)
      ALU_ADDU: r = alu_a + alu_b;
      ALU_ADD: begin
        r = alu_a + alu_b;
        v = (alu_a[N-1] == alu_b[N-1]) && (r[N-1] != alu_a[N-1]);
      end
      ALU_SUBU: r = alu_a - alu_b;
      ALU_SUB: begin
        r = alu_a - alu_b;
        v = (alu_a[N-1] != alu_b[N-1]) && (r[N-1] != alu_a[N-1]);
      end
      ALU_AND:  r = alu_a & alu_b;
      ALU_OR:   r = alu_a | alu_b;
      ALU_SLT:  r = {{(N-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU: r = {{(N-1){1'b0}}, (alu_a < alu_b)};
      default:  r = '0;
    endcase
    if (inj_en) begin
      r = inj_val;
      v = 1'b0;
    end
    alu_result   = r;
    alu_zero     = (r == '0);
    alu_overflow = v;
  end

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_check(input string tag, input logic [REG_AW-1:0] a, input logic [N-1:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Issues one command, checks handshake and done_valid timing, returns one cycle after WB.
  task automatic run_op(input logic [2:0] op, input logic [REG_AW-1:0] rs,
                        input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd);
    int n = 0;
    while (!cmd_ready && n < 8) begin
      step();
      n++;
    end
    check("ready_before_issue", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rs    = rs;
    cmd_rt    = rt;
    cmd_rd    = rd;
    step();                                        // accepting edge T
    cmd_valid = 1'b0;
    check("ready_low_read", {31'b0, cmd_ready}, 32'd0);
    step();                                        // T+1: EXEC
    check("done_low_exec", {31'b0, done_valid}, 32'd0);
    step();                                        // T+2: WB
    check("done_pulse", {31'b0, done_valid}, 32'd1);
    step();                                        // T+3: back to IDLE
    check("done_drop", {31'b0, done_valid}, 32'd0);
  endtask

  task automatic preload(input logic [REG_AW-1:0] rd, input logic [N-1:0] val);
    inj_en  = 1'b1;
    inj_val = val;
    run_op(ALU_ADDU, '0, '0, rd);
    inj_en  = 1'b0;
  endtask

  initial begin
    logic [N-1:0] exp_r6;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_rs    = '0;
    cmd_rt    = '0;
    cmd_rd    = '0;
    dbg_addr  = '0;
    inj_en    = 1'b0;
    inj_val   = '0;

    // Reset state
    repeat (2) step();
    check("rst_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_done_valid", {31'b0, done_valid}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_done_result", done_result, 32'd0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < (1 << REG_AW); i++) dbg_check("rst_regfile", REG_AW'(i), 32'd0);

    // Preload and basic ADDU
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd3);
    dbg_check("r1_preload", 5'd1, 32'd5);
    dbg_check("r2_preload", 5'd2, 32'd3);
    run_op(ALU_ADDU, 5'd1, 5'd2, 5'd3);
    check("addu_result", done_result, 32'd8);
    check("addu_zero", {31'b0, done_zero}, 32'd0);
    check("addu_ovf", {31'b0, done_overflow}, 32'd0);
    check("addu_alu_a", alu_a, 32'd5);
    check("addu_alu_b", alu_b, 32'd3);
    check("addu_alu_ctr", {29'b0, alu_ctr}, {29'b0, ALU_ADDU});
    dbg_check("r3_after_addu", 5'd3, 32'd8);

    // Signed overflow on ADD
    preload(5'd4, 32'h7FFF_FFFF);
    preload(5'd5, 32'd1);
    preload(5'd6, 32'h0000_1234);
    run_op(ALU_ADD, 5'd4, 5'd5, 5'd6);
    check("add_ovf_flag", {31'b0, done_overflow}, 32'd1);
    check("add_ovf_result", done_result, 32'h8000_0000);
`ifdef OVF_WB_SUPPRESS_EN
    exp_r6 = 32'h0000_1234;
`else
    exp_r6 = 32'h8000_0000;
`endif
    dbg_check("r6_after_ovf", 5'd6, exp_r6);

    // Register 0 stays zero
    preload(5'd0, 32'h0000_DEAD);
    check("r0_inj_captured", done_result, 32'h0000_DEAD);
    dbg_check("r0_after_inj", 5'd0, 32'd0);
    run_op(ALU_SUBU, 5'd1, 5'd1, 5'd0);
    check("subu_zero_flag", {31'b0, done_zero}, 32'd1);
    check("subu_zero_result", done_result, 32'd0);
    dbg_check("r0_after_subu", 5'd0, 32'd0);

    // Assorted operations
    run_op(ALU_SUB, 5'd2, 5'd1, 5'd7);
    check("sub_result", done_result, 32'hFFFF_FFFE);
    check("sub_ovf", {31'b0, done_overflow}, 32'd0);
    run_op(ALU_SLT, 5'd7, 5'd1, 5'd8);
    check("slt_result", done_result, 32'd1);
    run_op(ALU_SLTU, 5'd7, 5'd1, 5'd9);
    check("sltu_result", done_result, 32'd0);
    check("sltu_zero", {31'b0, done_zero}, 32'd1);
    run_op(ALU_AND, 5'd4, 5'd2, 5'd9);
    check("and_result", done_result, 32'd3);
    dbg_check("r9_after_and", 5'd9, 32'd3);
    run_op(ALU_OR, 5'd1, 5'd1, 5'd12);
    check("rs_eq_rt_a", alu_a, 32'd5);
    check("rs_eq_rt_b", alu_b, 32'd5);
    check("or_result", done_result, 32'd5);
    run_op(ALU_ADDU, 5'd1, 5'd2, 5'd1);
    check("rd_eq_rs_result", done_result, 32'd8);
    dbg_check("r1_after_self", 5'd1, 32'd8);

    // Back-to-back with cmd_valid held; second op depends on the first
    cmd_valid = 1'b1;
    cmd_op    = ALU_ADDU;
    cmd_rs    = 5'd2;
    cmd_rt    = 5'd2;
    cmd_rd    = 5'd10;
    step();
    cmd_rs = 5'd10;
    cmd_rt = 5'd2;
    cmd_rd = 5'd11;
    check("b2b_ready_c1", {31'b0, cmd_ready}, 32'd0);
    step();
    check("b2b_ready_c2", {31'b0, cmd_ready}, 32'd0);
    step();
    check("b2b_ready_c3", {31'b0, cmd_ready}, 32'd0);
    check("b2b_op1_result", done_result, 32'd6);
    step();
    check("b2b_ready_idle", {31'b0, cmd_ready}, 32'd1);
    dbg_check("b2b_r10", 5'd10, 32'd6);
    step();
    cmd_valid = 1'b0;
    check("b2b_ready_op2", {31'b0, cmd_ready}, 32'd0);
    step();
    step();
    check("b2b_op2_done", {31'b0, done_valid}, 32'd1);
    check("b2b_op2_result", done_result, 32'd9);
    step();
    dbg_check("b2b_r11", 5'd11, 32'd9);

    // Reset during EXEC
    cmd_valid = 1'b1;
    cmd_op    = ALU_ADDU;
    cmd_rs    = 5'd1;
    cmd_rt    = 5'd2;
    cmd_rd    = 5'd13;
    step();
    cmd_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'b0, cmd_ready}, 32'd1);
    check("midrst_done_valid", {31'b0, done_valid}, 32'd0);
    check("midrst_alu_a", alu_a, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_no_pulse", {31'b0, done_valid}, 32'd0);
    end
    rst_n = 1'b1;
    step();
    check("postrst_ready", {31'b0, cmd_ready}, 32'd1);
    dbg_check("postrst_r13", 5'd13, 32'd0);
    dbg_check("postrst_r1", 5'd1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
